id_ex_stage: RTL

- Pipeline register between instruction decode and the EX-stage ALU.
- Captures decoded operands and control on each clock, then derives the 3-bit ALU control code from ALUOp/funct.
- Resolves EX/MEM and MEM/WB data forwarding, and drives the ALU's data1/data2/ALUCtrl inputs directly.
- Supports stall (hold) and flush (bubble) from the hazard unit.

---
 rtl/id_ex_stage.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the EX-stage ALU.
// Holds decoded operands and control, decodes the ALU code and resolves EX/MEM and MEM/WB forwarding.
module id_ex_stage #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] RSdata_i,
  input  logic [WIDTH-1:0] RTdata_i,
  input  logic [WIDTH-1:0] imm_i,
  input  logic [AW-1:0]    RSaddr_i,
  input  logic [AW-1:0]    RTaddr_i,
  input  logic [AW-1:0]    RDaddr_i,
  input  logic [5:0]       funct_i,
  input  logic [1:0]       ALUOp_i,
  input  logic             ALUSrc_i,
  input  logic             RegDst_i,
  input  logic             RegWrite_i,
  input  logic             MemtoReg_i,
  input  logic             MemRead_i,
  input  logic             MemWrite_i,
  input  logic             EXMEM_RegWrite_i,
  input  logic [AW-1:0]    EXMEM_RDaddr_i,
  input  logic [WIDTH-1:0] EXMEM_data_i,
  input  logic             MEMWB_RegWrite_i,
  input  logic [AW-1:0]    MEMWB_RDaddr_i,
  input  logic [WIDTH-1:0] MEMWB_data_i,
  output logic [WIDTH-1:0] data1_o,
  output logic [WIDTH-1:0] data2_o,
  output logic [2:0]       ALUCtrl_o,
  output logic [WIDTH-1:0] MemWdata_o,
  output logic [AW-1:0]    WBaddr_o,
  output logic             RegWrite_o,
  output logic             MemtoReg_o,
  output logic             MemRead_o,
  output logic             MemWrite_o,
  output logic             illegal_o
);

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_MUL = 6'b011000;

  localparam logic [2:0] CTRL_ADD = 3'b010;
  localparam logic [2:0] CTRL_SUB = 3'b110;
  localparam logic [2:0] CTRL_AND = 3'b000;
  localparam logic [2:0] CTRL_OR  = 3'b001;
  localparam logic [2:0] CTRL_MUL = 3'b100;

  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic [WIDTH-1:0] imm;
  logic [AW-1:0]    rs_addr;
  logic [AW-1:0]    rt_addr;
  logic [AW-1:0]    rd_addr;
  logic [5:0]       funct;
  logic [1:0]       alu_op;
  logic             alu_src;
  logic             reg_dst;
  logic             reg_write;
  logic             memto_reg;
  logic             mem_read;
  logic             mem_write;
  logic             illegal;
  logic             capture_illegal;
  logic             load_fields;
  logic [WIDTH-1:0] fwd_rs;
  logic [WIDTH-1:0] fwd_rt;

  always_comb begin
    capture_illegal = 1'b0;
    if (ALUOp_i == 2'b10) begin
      case (funct_i)
        FUNCT_ADD, FUNCT_SUB, FUNCT_AND, FUNCT_OR, FUNCT_MUL: capture_illegal = 1'b0;
        default:                                               capture_illegal = 1'b1;
      endcase
    end
  end

  // A flush still loads the data fields; only the control bits are forced to a bubble.
  assign load_fields = flush_i | ~stall_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rs_data   <= '0;
      rt_data   <= '0;
      imm       <= '0;
      rs_addr   <= '0;
      rt_addr   <= '0;
      rd_addr   <= '0;
      funct     <= '0;
      alu_op    <= '0;
      alu_src   <= 1'b0;
      reg_dst   <= 1'b0;
      reg_write <= 1'b0;
      memto_reg <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      if (load_fields) begin
        rs_data <= RSdata_i;
        rt_data <= RTdata_i;
        imm     <= imm_i;
        rs_addr <= RSaddr_i;
        rt_addr <= RTaddr_i;
        rd_addr <= RDaddr_i;
        funct   <= funct_i;
        alu_op  <= ALUOp_i;
        alu_src <= ALUSrc_i;
        reg_dst <= RegDst_i;
      end
      if (flush_i) begin
        reg_write <= 1'b0;
        memto_reg <= 1'b0;
        mem_read  <= 1'b0;
        mem_write <= 1'b0;
        illegal   <= 1'b0;
      end else if (!stall_i) begin
        reg_write <= RegWrite_i;
        memto_reg <= MemtoReg_i;
        mem_read  <= MemRead_i;
        mem_write <= MemWrite_i;
        illegal   <= capture_illegal;
      end
    end
  end

  always_comb begin
    ALUCtrl_o = CTRL_ADD;
    case (alu_op)
      2'b01: ALUCtrl_o = CTRL_SUB;
      2'b10: begin
        case (funct)
          FUNCT_SUB: ALUCtrl_o = CTRL_SUB;
          FUNCT_AND: ALUCtrl_o = CTRL_AND;
          FUNCT_OR:  ALUCtrl_o = CTRL_OR;
          FUNCT_MUL: ALUCtrl_o = CTRL_MUL;
          default:   ALUCtrl_o = CTRL_ADD;
        endcase
      end
      default: ALUCtrl_o = CTRL_ADD;
    endcase
  end

  // The younger EX/MEM result wins over MEM/WB; register 0 is hardwired and never forwarded.
  always_comb begin
    fwd_rs = rs_data;
    if (EXMEM_RegWrite_i && (EXMEM_RDaddr_i != '0) && (EXMEM_RDaddr_i == rs_addr)) begin
      fwd_rs = EXMEM_data_i;
    end else if (MEMWB_RegWrite_i && (MEMWB_RDaddr_i != '0) && (MEMWB_RDaddr_i == rs_addr)) begin
      fwd_rs = MEMWB_data_i;
    end
  end

  always_comb begin
    fwd_rt = rt_data;
    if (EXMEM_RegWrite_i && (EXMEM_RDaddr_i != '0) && (EXMEM_RDaddr_i == rt_addr)) begin
      fwd_rt = EXMEM_data_i;
    end else if (MEMWB_RegWrite_i && (MEMWB_RDaddr_i != '0) && (MEMWB_RDaddr_i == rt_addr)) begin
      fwd_rt = MEMWB_data_i;
    end
  end

  assign data1_o    = fwd_rs;
  assign MemWdata_o = fwd_rt;
  assign data2_o    = alu_src ? imm : fwd_rt;
  assign WBaddr_o   = reg_dst ? rd_addr : rt_addr;
  assign RegWrite_o = reg_write;
  assign MemtoReg_o = memto_reg;
  assign MemRead_o  = mem_read;
  assign MemWrite_o = mem_write;
  assign illegal_o  = illegal;

endmodule
